// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts an instruction, reads two register operands with
// writeback forwarding, and holds the decoded bundle until downstream takes it.
module operand_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  rf_addr_a,
  output logic [2:0]  rf_addr_b,
  input  logic [15:0] rf_data_a,
  input  logic [15:0] rf_data_b,
  input  logic        wb_en,
  input  logic [2:0]  wb_dest,
  input  logic [15:0] wb_data,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [3:0]  op_opcode,
  output logic [2:0]  op_dest,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        op_use_imm
);

  typedef enum logic [1:0] {StIdle, StRead, StValid} state_e;

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [2:0]  dest_q, dest_d;
  logic [2:0]  src_a_q, src_a_d;
  logic [2:0]  src_b_q, src_b_d;
  logic [5:0]  imm_q, imm_d;
  logic        fwd_a_q, fwd_a_d;
  logic        fwd_b_q, fwd_b_d;
  logic [15:0] fwd_data_a_q, fwd_data_a_d;
  logic [15:0] fwd_data_b_q, fwd_data_b_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;

  logic        accept;
  logic        use_imm;
  logic        wb_hit_a, wb_hit_b;
  logic [15:0] imm_sext;

  assign rf_addr_a = instr[8:6];
  assign rf_addr_b = instr[5:3];

  // Ready is gated by rst_n so it reads 0 throughout reset, not just after it.
  assign instr_ready = rst_n && !flush &&
                       ((state_q == StIdle) || ((state_q == StValid) && op_ready));
  assign accept      = instr_valid && instr_ready;

  assign use_imm  = opcode_q[3];
  assign wb_hit_a = wb_en && (wb_dest == src_a_q);
  assign wb_hit_b = wb_en && (wb_dest == src_b_q);
  assign imm_sext = {{10{imm_q[5]}}, imm_q};

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    dest_d       = dest_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    imm_d        = imm_q;
    fwd_a_d      = fwd_a_q;
    fwd_b_d      = fwd_b_q;
    fwd_data_a_d = fwd_data_a_q;
    fwd_data_b_d = fwd_data_b_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StRead;
      end
      StRead: begin
        state_d = StValid;
        op_a_d  = wb_hit_a ? wb_data : (fwd_a_q ? fwd_data_a_q : rf_data_a);
        if (use_imm) begin
          op_b_d = imm_sext;
        end else begin
          op_b_d = wb_hit_b ? wb_data : (fwd_b_q ? fwd_data_b_q : rf_data_b);
        end
      end
      StValid: begin
        if (op_ready) begin
          state_d = accept ? StRead : StIdle;
        end else begin
          // Track late writebacks so the held bundle never goes stale.
          if (wb_hit_a) op_a_d = wb_data;
          if (wb_hit_b && !use_imm) op_b_d = wb_data;
        end
      end
      default: state_d = StIdle;
    endcase

    // The file returns the pre-write value for the accept edge, so remember that write.
    if (accept) begin
      opcode_d     = instr[15:12];
      dest_d       = instr[11:9];
      src_a_d      = instr[8:6];
      src_b_d      = instr[5:3];
      imm_d        = instr[5:0];
      fwd_a_d      = wb_en && (wb_dest == instr[8:6]);
      fwd_b_d      = wb_en && (wb_dest == instr[5:3]);
      fwd_data_a_d = wb_data;
      fwd_data_b_d = wb_data;
    end

    if (flush) begin
      state_d = StIdle;
      fwd_a_d = 1'b0;
      fwd_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      opcode_q     <= '0;
      dest_q       <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      imm_q        <= '0;
      fwd_a_q      <= 1'b0;
      fwd_b_q      <= 1'b0;
      fwd_data_a_q <= '0;
      fwd_data_b_q <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      dest_q       <= dest_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      imm_q        <= imm_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      fwd_data_a_q <= fwd_data_a_d;
      fwd_data_b_q <= fwd_data_b_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
    end
  end

  assign op_valid   = (state_q == StValid);
  assign op_opcode  = opcode_q;
  assign op_dest    = dest_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_use_imm = use_imm;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port flush, input, 1: synchronous discard of in-flight instruction.
REQ-004 SHALL have port instr_valid, input, 1: upstream instruction present.
REQ-005 SHALL have port instr, input, 16: instruction word; [15:12] opcode, [11:9] dest, [8:6] src_a, [5:3] src_b, [5:0] imm6.
REQ-006 SHALL have port instr_ready, output, 1: block accepts instr this cycle.
REQ-007 SHALL have port rf_addr_a, output, 3: register-file read address A.
REQ-008 SHALL have port rf_addr_b, output, 3: register-file read address B.
REQ-009 SHALL have port rf_data_a, input, 16: registered read data A, one-cycle latency from address.
REQ-010 SHALL have port rf_data_b, input, 16: registered read data B, one-cycle latency from address.
REQ-011 SHALL have port wb_en, input, 1: writeback to register file this cycle.
REQ-012 SHALL have port wb_dest, input, 3: writeback destination register.
REQ-013 SHALL have port wb_data, input, 16: writeback data.
REQ-014 SHALL have port op_valid, output, 1: decoded operand bundle valid.
REQ-015 SHALL have port op_ready, input, 1: downstream accepts bundle.
REQ-016 SHALL have port op_opcode, output, 4: latched opcode.
REQ-017 SHALL have port op_dest, output, 3: latched destination register.
REQ-018 SHALL have port op_a, output, 16: operand A.
REQ-019 SHALL have port op_b, output, 16: operand B or sign-extended immediate.
REQ-020 SHALL have port op_use_imm, output, 1: op_b carries the immediate.

Function
REQ-021 SHALL drive rf_addr_a = instr[8:6] and rf_addr_b = instr[5:3] combinationally at all times.
REQ-022 SHALL implement states IDLE, READ, VALID; instr_ready = !flush && (IDLE || (VALID && op_ready)).
REQ-023 SHALL, on accept edge (instr_valid && instr_ready), latch opcode, dest, src_a, src_b, imm6 and enter READ.
REQ-024 SHALL, in READ, at the next edge capture operands, assert op_valid, enter VALID; latency accept-edge to op_valid = 1 cycle.
REQ-025 SHALL set op_use_imm = opcode[3]; when set, op_b = {10 copies of imm6[5], imm6}, never register data or forwarded data.
REQ-026 SHALL, at accept edge, record fwd_x/fwd_data_x when wb_en && wb_dest == src_x (file returns pre-write value for that edge).
REQ-027 SHALL, at READ capture edge, select per operand: wb_data if wb_en && wb_dest == src_x; else recorded fwd_data_x; else rf_data_x.
REQ-028 SHALL, in VALID without handshake, overwrite op_a/op_b (register operand only) with wb_data when wb_en && wb_dest == src_x.
REQ-029 SHALL, on VALID && op_ready: go to READ if a new instr is accepted same edge, else to IDLE with op_valid = 0.
REQ-030 SHALL hold op_* stable in VALID while op_ready = 0, except REQ-028 updates.
REQ-031 SHALL, on flush, go to IDLE, clear op_valid and fwd flags at that edge; flush wins over simultaneous accept or handshake.
REQ-032 SHALL treat src_a == src_b with both matching wb_dest by forwarding to both operands.

Reset
REQ-033 SHALL, while rst_n = 0, force state IDLE, op_valid 0, instr_ready 0, op_opcode/op_dest/op_a/op_b 0, op_use_imm 0, fwd flags 0, regardless of clk.
REQ-034 SHALL abandon any in-flight instruction on reset assertion mid-operation; after release, first accept behaves as from cold.

Verification
REQ-035 SHALL pass: instr 0x0298 (opcode 0, dest 1, src_a 2, src_b 3), R2=0x1111, R3=0x2222 -> op_valid one cycle after accept, op_a 0x1111, op_b 0x2222, op_dest 1.
REQ-036 SHALL pass: opcode 0x8, imm6 0x3E -> op_use_imm 1, op_b 0xFFFE; wb to src_b ignored.
REQ-037 SHALL pass: wb_en, wb_dest 2, wb_data 0xBEEF on accept edge, R2 stale 0x1111 -> op_a 0xBEEF.
REQ-038 SHALL pass: op_ready held 0 three cycles, wb to src_a with 0x0042 in cycle 2 -> op_a becomes 0x0042, others unchanged, single handshake.
REQ-039 SHALL pass: op_ready and instr_valid held 1 -> one bundle per two cycles, no drops or duplicates over 8 instructions.
REQ-040 SHALL pass: flush in READ, then rst_n pulsed low mid-VALID -> op_valid 0 next edge / immediately; no stale bundle emitted afterwards.
